// File: rtl/archie_upload_reader_if.sv
// Wishbone classic read bus between the upload reader (master) and sdram_top (slave).
interface archie_upload_reader_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr,
    output wb_dat_i, wb_ack
  );
endinterface

// File: rtl/archie_upload_reader.sv
// Serves HPS upload reads from SDRAM over wishbone, with a one-word sequential prefetch.
module archie_upload_reader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_32m,
  input  logic                   reset,
  input  logic                   upload_active,
  input  logic                   upload_rd,
  input  logic [24:0]            upload_addr,
  output logic [31:0]            upload_din,
  output logic                   upload_wait,
  output logic                   timeout_err,
  archie_upload_reader_if.master wb
);
  typedef enum logic [2:0] {IDLE, DEMAND, PREF, PREF_MISS, DRAIN} state_t;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        stb_q, stb_d;
  logic [21:0] adr_q, adr_d;
  logic [31:0] din_q, din_d;
  logic        wait_q, wait_d;
  logic        err_q, err_d;
  logic [21:0] pf_addr_q, pf_addr_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic [21:0] req_addr_q, req_addr_d;
  logic        deliver_q, deliver_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        active_q;

  logic [21:0] rd_word;
  logic        ack, tmo_hit, rd_ok;
  logic        unused_addr_bits;

  assign rd_word          = upload_addr[23:2];
  assign unused_addr_bits = ^{upload_addr[24], upload_addr[1:0]};
  assign ack              = stb_q & wb.wb_ack;
  assign tmo_hit          = stb_q & ~wb.wb_ack & (tmo_q == TMO_LAST);
  assign rd_ok            = upload_rd & upload_active & ~wait_q;

  // adr_q is the word address of the open cycle, or of the cycle launched after a one-cycle gap
  // (stb_q low while in DEMAND/PREF).
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    adr_d      = adr_q;
    din_d      = din_q;
    wait_d     = wait_q;
    err_d      = err_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
    req_addr_d = req_addr_q;
    deliver_d  = deliver_q;
    tmo_d      = stb_q ? tmo_q + 10'd1 : '0;

    if (upload_active && !active_q) err_d = 1'b0;

    if (!upload_active) begin
      wait_d     = 1'b0;
      pf_valid_d = 1'b0;
      deliver_d  = 1'b0;
      if (stb_q && !ack && !tmo_hit) begin
        state_d = DRAIN;
      end else begin
        state_d = IDLE;
        stb_d   = 1'b0;
        if (tmo_hit) err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: if (rd_ok) begin
          stb_d = 1'b1;
          if (pf_valid_q && rd_word == pf_addr_q) begin
            din_d   = pf_data_q;
            adr_d   = pf_addr_q + 22'd1;
            state_d = PREF;
          end else begin
            wait_d     = 1'b1;
            pf_valid_d = 1'b0;
            req_addr_d = rd_word;
            adr_d      = rd_word;
            state_d    = DEMAND;
          end
        end
        DEMAND: begin
          if (!stb_q) begin
            stb_d = 1'b1;
          end else if (ack) begin
            din_d   = wb.wb_dat_i;
            wait_d  = 1'b0;
            stb_d   = 1'b0;
            adr_d   = req_addr_q + 22'd1;
            state_d = PREF;
          end else if (tmo_hit) begin
            din_d   = '1;
            wait_d  = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        PREF: begin
          if (!stb_q) begin
            stb_d = 1'b1;
            if (rd_ok) begin
              wait_d = 1'b1;
              if (rd_word == adr_q) begin
                deliver_d = 1'b1;
              end else begin
                pf_valid_d = 1'b0;
                req_addr_d = rd_word;
                adr_d      = rd_word;
                state_d    = DEMAND;
              end
            end
          end else if (ack || tmo_hit) begin
            stb_d   = 1'b0;
            state_d = IDLE;
            if (tmo_hit) err_d = 1'b1;
            if (deliver_q) begin
              din_d     = ack ? wb.wb_dat_i : '1;
              wait_d    = 1'b0;
              deliver_d = 1'b0;
              if (ack) begin
                req_addr_d = adr_q;
                adr_d      = adr_q + 22'd1;
                state_d    = PREF;
              end
            end else if (rd_ok && ack && rd_word == adr_q) begin
              // read lands on the very cycle its prefetch completes: forward and keep streaming
              din_d      = wb.wb_dat_i;
              pf_data_d  = wb.wb_dat_i;
              pf_addr_d  = adr_q;
              pf_valid_d = 1'b1;
              adr_d      = adr_q + 22'd1;
              state_d    = PREF;
            end else if (rd_ok) begin
              wait_d     = 1'b1;
              pf_valid_d = 1'b0;
              req_addr_d = rd_word;
              adr_d      = rd_word;
              state_d    = DEMAND;
            end else if (ack) begin
              pf_data_d  = wb.wb_dat_i;
              pf_addr_d  = adr_q;
              pf_valid_d = 1'b1;
            end
          end else if (rd_ok) begin
            wait_d = 1'b1;
            if (rd_word == adr_q) begin
              deliver_d = 1'b1;
            end else begin
              pf_valid_d = 1'b0;
              req_addr_d = rd_word;
              state_d    = PREF_MISS;
            end
          end
        end
        PREF_MISS: if (ack || tmo_hit) begin
          stb_d   = 1'b0;
          adr_d   = req_addr_q;
          state_d = DEMAND;
          if (tmo_hit) err_d = 1'b1;
        end
        DRAIN: if (ack || tmo_hit || !stb_q) begin
          stb_d   = 1'b0;
          state_d = IDLE;
          if (tmo_hit) err_d = 1'b1;
        end
        default: begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32m) begin
    if (reset) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      din_q      <= '0;
      wait_q     <= 1'b0;
      err_q      <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
      req_addr_q <= '0;
      deliver_q  <= 1'b0;
      tmo_q      <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
      req_addr_q <= req_addr_d;
      deliver_q  <= deliver_d;
      tmo_q      <= tmo_d;
      active_q   <= upload_active;
    end
  end

  assign upload_din  = din_q;
  assign upload_wait = wait_q;
  assign timeout_err = err_q;
  assign wb.wb_cyc   = stb_q;
  assign wb.wb_stb   = stb_q;
  assign wb.wb_we    = 1'b0;
  assign wb.wb_sel   = 4'b1111;
  assign wb.wb_cti   = 3'b000;
  assign wb.wb_adr   = {2'b00, adr_q, 2'b00};
endmodule

// File: tb/tb_archie_upload_reader.sv
// Bench for archie_upload_reader: SDRAM slave model, bus monitor and read-data scoreboard.
module tb_archie_upload_reader;
  logic        clk_32m = 1'b0;
  logic        reset = 1'b1;
  logic        upload_active = 1'b0;
  logic        upload_rd = 1'b0;
  logic [24:0] upload_addr = '0;
  logic [31:0] upload_din;
  logic        upload_wait;
  logic        timeout_err;

  archie_upload_reader_if wb_bus ();

  archie_upload_reader #(.TIMEOUT(16)) dut (
    .clk_32m(clk_32m),
    .reset(reset),
    .upload_active(upload_active),
    .upload_rd(upload_rd),
    .upload_addr(upload_addr),
    .upload_din(upload_din),
    .upload_wait(upload_wait),
    .timeout_err(timeout_err),
    .wb(wb_bus)
  );

  always #5 clk_32m = ~clk_32m;

  int          checks = 0;
  int          errors = 0;
  int          ack_lat = 4;
  bit          no_ack = 1'b0;
  logic [31:0] exp_q[$];
  logic [25:0] bus_log[$];
  int          gap_log[$];
  int          cyc = 0;
  int          fall_cyc = 0;
  int          hi_len = 0;
  int          last_hi_len = 0;

  function automatic logic [31:0] mem_word(input logic [21:0] w);
    return {w, 10'h000} ^ 32'hC3A5_0F1E ^ {22'b0, w[9:0]};
  endfunction

  function automatic logic [31:0] mem_at(input logic [24:0] a);
    return mem_word(a[23:2]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_32m);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [24:0] a, input logic [31:0] expv,
                         output bit stalled);
    int budget;
    @(negedge clk_32m);
    upload_addr = a;
    upload_rd   = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk_32m);
    #1;
    upload_rd = 1'b0;
    stalled   = upload_wait;
    budget    = 100;
    while (upload_wait && budget > 0) begin
      @(posedge clk_32m);
      #1;
      budget--;
    end
    check_eq({tag, "_done"}, {31'b0, upload_wait}, 32'd0);
    check_eq(tag, upload_din, exp_q.pop_front());
  endtask

  task automatic wait_stb();
    int budget;
    budget = 50;
    while (!wb_bus.wb_stb && budget > 0) begin
      @(posedge clk_32m);
      #1;
      budget--;
    end
    check_eq("stb_seen", {31'b0, wb_bus.wb_stb}, 32'd1);
  endtask

  // SDRAM slave: acks after ack_lat cycles of stb, data from the memory model
  initial begin
    int cnt;
    cnt = 0;
    wb_bus.wb_ack   = 1'b0;
    wb_bus.wb_dat_i = '0;
    forever begin
      @(negedge clk_32m);
      if (wb_bus.wb_stb && !wb_bus.wb_ack) begin
        cnt++;
        if (!no_ack && cnt >= ack_lat) begin
          wb_bus.wb_ack   = 1'b1;
          wb_bus.wb_dat_i = mem_word(wb_bus.wb_adr[23:2]);
        end
      end else begin
        wb_bus.wb_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Bus monitor: logs cycle addresses, idle gaps and stb-high lengths
  initial begin
    logic        stb_prev;
    logic [25:0] adr_prev;
    stb_prev = 1'b0;
    adr_prev = '0;
    forever begin
      @(negedge clk_32m);
      cyc++;
      if (wb_bus.wb_stb) begin
        if (!stb_prev) begin
          bus_log.push_back(wb_bus.wb_adr);
          gap_log.push_back(cyc - fall_cyc);
          hi_len = 0;
        end else begin
          check_eq("adr_stable", {6'b0, wb_bus.wb_adr}, {6'b0, adr_prev});
        end
        check_eq("cyc_with_stb", {31'b0, wb_bus.wb_cyc}, 32'd1);
        hi_len++;
      end else if (stb_prev) begin
        fall_cyc    = cyc;
        last_hi_len = hi_len;
      end
      stb_prev = wb_bus.wb_stb;
      adr_prev = wb_bus.wb_adr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int n304;

    // reset state
    cycles(3);
    check_eq("rst_din", upload_din, 32'd0);
    check_eq("rst_wait", {31'b0, upload_wait}, 32'd0);
    check_eq("rst_stb", {31'b0, wb_bus.wb_stb}, 32'd0);
    check_eq("rst_cyc", {31'b0, wb_bus.wb_cyc}, 32'd0);
    check_eq("rst_adr", {6'b0, wb_bus.wb_adr}, 32'd0);
    check_eq("rst_err", {31'b0, timeout_err}, 32'd0);
    check_eq("const_we", {31'b0, wb_bus.wb_we}, 32'd0);
    check_eq("const_sel", {28'b0, wb_bus.wb_sel}, 32'hF);
    check_eq("const_cti", {29'b0, wb_bus.wb_cti}, 32'd0);
    @(negedge clk_32m);
    reset = 1'b0;
    upload_active = 1'b1;
    cycles(2);

    // sequential stream, latency 4, one read per 16 cycles
    bus_log.delete();
    gap_log.delete();
    for (int i = 0; i < 16; i++) begin
      int t0;
      t0 = cyc;
      do_read("seq_data", 25'(i * 4), mem_at(25'(i * 4)), st);
      if (i == 0) check_eq("seq_first_stall", {31'b0, st}, 32'd1);
      else        check_eq("seq_no_stall", {31'b0, st}, 32'd0);
      while (cyc - t0 < 16) @(negedge clk_32m);
    end
    cycles(10);
    check_eq("seq_bus_reads", bus_log.size(), 17);
    check_eq("seq_last_adr", {6'b0, bus_log[16]}, 32'h40);
    check_eq("seq_pref_gap", gap_log[1], 1);

    // random jump during a prefetch
    bus_log.delete();
    gap_log.delete();
    do_read("jump_first", 25'h100, mem_at(25'h100), st);
    wait_stb();
    do_read("jump_data", 25'h2000, mem_at(25'h2000), st);
    check_eq("jump_stall", {31'b0, st}, 32'd1);
    cycles(12);
    check_eq("jump_pref_adr", {6'b0, bus_log[1]}, 32'h104);
    check_eq("jump_dem_adr", {6'b0, bus_log[2]}, 32'h2000);
    check_eq("jump_gap", gap_log[2], 1);

    // read at the address being prefetched
    bus_log.delete();
    do_read("inflt_first", 25'h300, mem_at(25'h300), st);
    wait_stb();
    do_read("inflt_data", 25'h304, mem_at(25'h304), st);
    check_eq("inflt_stall", {31'b0, st}, 32'd1);
    cycles(12);
    n304 = 0;
    foreach (bus_log[k]) if (bus_log[k] == 26'h304) n304++;
    check_eq("inflt_one_read", n304, 1);
    check_eq("inflt_next_pref", {6'b0, bus_log[2]}, 32'h308);

    // slave never acks
    bus_log.delete();
    no_ack = 1'b1;
    do_read("tmo_data", 25'h500, 32'hFFFF_FFFF, st);
    check_eq("tmo_stall", {31'b0, st}, 32'd1);
    cycles(10);
    check_eq("tmo_stb_len", last_hi_len, 16);
    check_eq("tmo_err", {31'b0, timeout_err}, 32'd1);
    check_eq("tmo_no_pref", bus_log.size(), 1);
    no_ack = 1'b0;
    @(negedge clk_32m);
    upload_active = 1'b0;
    cycles(3);
    check_eq("tmo_err_sticky", {31'b0, timeout_err}, 32'd1);
    @(negedge clk_32m);
    upload_active = 1'b1;
    @(posedge clk_32m);
    #1;
    check_eq("tmo_err_clear", {31'b0, timeout_err}, 32'd0);
    cycles(2);

    // upload window closes during a demand read
    bus_log.delete();
    ack_lat = 10;
    @(negedge clk_32m);
    upload_addr = 25'h600;
    upload_rd   = 1'b1;
    @(posedge clk_32m);
    #1;
    upload_rd = 1'b0;
    check_eq("drain_wait_hi", {31'b0, upload_wait}, 32'd1);
    cycles(2);
    @(negedge clk_32m);
    upload_active = 1'b0;
    @(posedge clk_32m);
    #1;
    check_eq("drain_wait_lo", {31'b0, upload_wait}, 32'd0);
    check_eq("drain_stb_held", {31'b0, wb_bus.wb_stb}, 32'd1);
    for (int b = 0; b < 30 && wb_bus.wb_stb; b++) cycles(1);
    cycles(10);
    check_eq("drain_stb_len", last_hi_len, 10);
    check_eq("drain_no_pref", bus_log.size(), 1);
    check_eq("drain_idle", {31'b0, wb_bus.wb_stb}, 32'd0);
    @(negedge clk_32m);
    upload_active = 1'b1;
    ack_lat = 4;
    cycles(2);

    // reset with a cycle open, then the old prefetch address must miss
    do_read("rst_pre", 25'h700, mem_at(25'h700), st);
    cycles(12);
    @(negedge clk_32m);
    upload_addr = 25'h900;
    upload_rd   = 1'b1;
    @(posedge clk_32m);
    #1;
    upload_rd = 1'b0;
    check_eq("rst_mid_stb_pre", {31'b0, wb_bus.wb_stb}, 32'd1);
    @(negedge clk_32m);
    reset = 1'b1;
    @(posedge clk_32m);
    #1;
    check_eq("rst_mid_stb", {31'b0, wb_bus.wb_stb}, 32'd0);
    check_eq("rst_mid_cyc", {31'b0, wb_bus.wb_cyc}, 32'd0);
    check_eq("rst_mid_wait", {31'b0, upload_wait}, 32'd0);
    check_eq("rst_mid_din", upload_din, 32'd0);
    check_eq("rst_mid_adr", {6'b0, wb_bus.wb_adr}, 32'd0);
    @(negedge clk_32m);
    reset = 1'b0;
    cycles(3);
    do_read("rst_after", 25'h704, mem_at(25'h704), st);
    check_eq("rst_after_miss", {31'b0, st}, 32'd1);
    cycles(12);

    // word address wrap, then a hit with address bit 24 set
    bus_log.delete();
    do_read("wrap_data", 25'hFF_FFFC, mem_at(25'hFF_FFFC), st);
    cycles(12);
    check_eq("wrap_dem_adr", {6'b0, bus_log[0]}, 32'h0FF_FFFC);
    check_eq("wrap_pref_adr", {6'b0, bus_log[1]}, 32'h0);
    do_read("hi_bit_data", 25'h100_0000, mem_word(22'h0), st);
    check_eq("hi_bit_hit", {31'b0, st}, 32'd0);
    cycles(12);
    check_eq("hi_bit_pref", {6'b0, bus_log[2]}, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
